// File: rtl/riscv_ascon_iter.sv
// Iterative Ascon-p: ROUNDS_PER_CYCLE rounds per clock, ceil(a/ROUNDS_PER_CYCLE) busy cycles (a=0 goes straight to DONE).
// Back-pressure: ready_o only in IDLE; the result is held on valid_o until ack_i, and clear_i aborts RUN or DONE.
package riscv_ascon_pkg;
  typedef struct packed {
    logic [63:0] x0;
    logic [63:0] x1;
    logic [63:0] x2;
    logic [63:0] x3;
    logic [63:0] x4;
  } ascon_state_t;
endpackage

module riscv_ascon_iter
  import riscv_ascon_pkg::*;
#(
  parameter int ROUNDS_PER_CYCLE = 2,
  parameter bit SWAP_ENDIANESS   = 1,
  parameter int MAX_ROUNDS       = 12
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start_i,
  input  logic [3:0]   rounds_i,
  input  logic         clear_i,
  input  ascon_state_t ascon_state_i,
  output logic         ready_o,
  output logic         busy_o,
  output logic         valid_o,
  input  logic         ack_i,
  output ascon_state_t ascon_state_o
);

  localparam logic [3:0] RPC4 = 4'(ROUNDS_PER_CYCLE);
  localparam logic [3:0] MAX4 = 4'(MAX_ROUNDS);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  function automatic logic [63:0] ror64(input logic [63:0] v, input int r);
    return (v >> r) | (v << (64 - r));
  endfunction

  function automatic ascon_state_t bswap(input ascon_state_t v);
    logic [319:0] a;
    logic [319:0] r;
    a = v;
    r = '0;
    for (int w = 0; w < 10; w++) begin
      for (int b = 0; b < 4; b++) begin
        r[w*32 + b*8 +: 8] = a[w*32 + (3-b)*8 +: 8];
      end
    end
    return r;
  endfunction

  function automatic ascon_state_t ascon_round(input ascon_state_t s, input logic [3:0] i);
    ascon_state_t x;
    ascon_state_t t;
    x = s;
    x.x2 = x.x2 ^ {56'b0, ~i, i};
    x.x0 = x.x0 ^ x.x4;
    x.x4 = x.x4 ^ x.x3;
    x.x2 = x.x2 ^ x.x1;
    // chi reads only the pre-chi lanes, hence the separate t copy
    t.x0 = x.x0 ^ (~x.x1 & x.x2);
    t.x1 = x.x1 ^ (~x.x2 & x.x3);
    t.x2 = x.x2 ^ (~x.x3 & x.x4);
    t.x3 = x.x3 ^ (~x.x4 & x.x0);
    t.x4 = x.x4 ^ (~x.x0 & x.x1);
    t.x1 = t.x1 ^ t.x0;
    t.x0 = t.x0 ^ t.x4;
    t.x3 = t.x3 ^ t.x2;
    t.x2 = ~t.x2;
    x.x0 = t.x0 ^ ror64(t.x0, 19) ^ ror64(t.x0, 28);
    x.x1 = t.x1 ^ ror64(t.x1, 61) ^ ror64(t.x1, 39);
    x.x2 = t.x2 ^ ror64(t.x2, 1)  ^ ror64(t.x2, 6);
    x.x3 = t.x3 ^ ror64(t.x3, 10) ^ ror64(t.x3, 17);
    x.x4 = t.x4 ^ ror64(t.x4, 7)  ^ ror64(t.x4, 41);
    return x;
  endfunction

  state_e       r_fsm;
  state_e       w_fsm_nxt;
  ascon_state_t r_state;
  logic [3:0]   r_idx;
  logic [3:0]   r_rem;
  logic         w_accept;
  logic [3:0]   w_a_eff;
  logic [3:0]   w_n;
  ascon_state_t w_load;
  ascon_state_t w_step;
  ascon_state_t w_out;
  ascon_state_t w_chain [0:ROUNDS_PER_CYCLE];

  assign w_a_eff = (rounds_i > MAX4) ? MAX4 : rounds_i;
  assign w_n     = (r_rem < RPC4) ? r_rem : RPC4;
  assign w_load  = SWAP_ENDIANESS ? bswap(ascon_state_i) : ascon_state_i;
  assign w_out   = SWAP_ENDIANESS ? bswap(r_state) : r_state;

  assign w_chain[0] = r_state;
  for (genvar k = 0; k < ROUNDS_PER_CYCLE; k++) begin : g_round
    assign w_chain[k+1] = ascon_round(w_chain[k], r_idx + 4'(k));
  end

  // Partial final group: take the chain tap after exactly w_n rounds
  always_comb begin
    w_step = w_chain[ROUNDS_PER_CYCLE];
    for (int j = 1; j < ROUNDS_PER_CYCLE; j++) begin
      if (w_n == 4'(j)) w_step = w_chain[j];
    end
  end

  always_comb begin
    w_fsm_nxt = r_fsm;
    w_accept  = 1'b0;
    case (r_fsm)
      S_IDLE: begin
        if (start_i && !clear_i) begin
          w_accept  = 1'b1;
          w_fsm_nxt = (w_a_eff == 4'd0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (clear_i)            w_fsm_nxt = S_IDLE;
        else if (r_rem <= RPC4) w_fsm_nxt = S_DONE;
      end
      S_DONE: begin
        if (clear_i || ack_i) w_fsm_nxt = S_IDLE;
      end
      default: w_fsm_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_fsm <= S_IDLE;
    else        r_fsm <= w_fsm_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst_n || (clear_i && r_fsm != S_IDLE)) begin
      r_state <= '0;
      r_idx   <= '0;
      r_rem   <= '0;
    end else if (w_accept) begin
      r_state <= w_load;
      r_idx   <= 4'd12 - w_a_eff;
      r_rem   <= w_a_eff;
    end else if (r_fsm == S_RUN) begin
      r_state <= w_step;
      r_idx   <= r_idx + w_n;
      r_rem   <= r_rem - w_n;
    end
  end

  assign ready_o       = (r_fsm == S_IDLE);
  assign busy_o        = (r_fsm == S_RUN);
  assign valid_o       = (r_fsm == S_DONE);
  assign ascon_state_o = valid_o ? w_out : '0;

endmodule
